cascade_mod_counter: RTL and testbench
======================================

// Module: cascade_mod_counter
// PURPOSE
//  Parametrised multi-digit modulo counter: successor to the single-digit mod-10 counter.
//  DIGITS cascaded cells of DIGIT_W bits, each counting modulo MODULUS (BCD with defaults).
//  Adds up/down, sync clear, parallel load, enable and a wrap pulse.
//  Used as a generic event/time counter feeding display and APB status logic.
// PARAMETERS
//  DIGITS   4   number of cascaded digit cells (>=1)
//  DIGIT_W  4   bits per digit
//  MODULUS  10  per-digit modulus, 2..2**DIGIT_W
//  W        -   localparam = DIGITS*DIGIT_W, total count width
// PORTS
//  clk       in   1  single clock, rising edge
//  rstn      in   1  asynchronous active-low reset
//  en        in   1  count enable, one step per cycle when high
//  up_dn     in   1  1 = count up, 0 = count down
//  clr       in   1  synchronous clear to zero
//  load      in   1  synchronous parallel load
//  load_val  in   W  value for load, digit i at [i*DIGIT_W +: DIGIT_W]
//  cnt       out  W  registered count, digit-packed
//  cout      out  1  registered one-cycle pulse on full-range wrap
// BEHAVIOUR
//  Reset:
//  - rstn low forces cnt=0 and cout=0 immediately (async). Release is synchronous to clk.
//  - Reset mid-count drops the in-progress value. No state survives reset.
//  Priority each cycle:
//  - clr > load > en. If none is active, cnt holds and cout=0.
//  - clr: cnt<=0, cout<=0.
//  - load: each digit <= min(load_val digit, MODULUS-1), i.e. out-of-range digits clamp. cout<=0.
//  Counting up (en=1, up_dn=1):
//  - Digit 0 always steps. Digit i steps only when all lower digits are at MODULUS-1.
//  - A stepping digit at MODULUS-1 wraps to 0; otherwise it increments.
//  Counting down (en=1, up_dn=0):
//  - Digit i steps only when all lower digits are at 0.
//  - A stepping digit at 0 wraps to MODULUS-1; otherwise it decrements.
//  Wrap pulse:
//  - cout=1 in the same cycle cnt shows the wrapped value. This applies to up all-(MODULUS-1)->0
//    and to down all-0->all-(MODULUS-1). Single cycle; continuous enable gives one pulse per wrap.
//  - Carry/borrow between digits is combinational within the cycle. Latency to cnt is 1 clock.
//  Other rules:
//  - Direction may change on any cycle with no penalty. The step uses that cycle's up_dn.
//  - Digit values are never >= MODULUS at any time, because reset, clr and load all enforce it.
// CONFIGURATION
//  CASCADE_CNT_CMP_EN defined:
//  - Adds input cmp_val[W-1:0] and output cmp_hit (1 bit).
//  - cmp_hit is registered: high in the cycle after cnt==cmp_val is observed. Reset value is 0.
//  CASCADE_CNT_CMP_EN undefined:
//  - Neither port exists. No compare logic is built.
// STRUCTURE
//  Package cascade_cnt_pkg:
//  - CNT_DIR_UP=1'b1, CNT_DIR_DN=1'b0.
//  - Default DIGITS/DIGIT_W/MODULUS constants.
//  - Function for the clamp-to-MODULUS-1 rule.
//  Sub-module mod_digit_cell, one per digit via generate:
//  - Inputs: clk, rstn, step, up_dn, clr, load, ld_digit.
//  - Outputs: digit, at_max, at_zero.
//  Top level:
//  - Forms the step chain from the lower digits' at_max/at_zero flags.
//  - Registers cout and, when configured, cmp_hit.
// TESTING (DIGITS=4, MODULUS=10, values in hex-BCD)
//  1. Reset: rstn=0 mid-count at cnt=16'h0457 -> cnt=16'h0000, cout=0 without waiting for a clk edge.
//  2. Up wrap: load 16'h9998, en=1, up_dn=1 -> 16'h9999, then 16'h0000 with cout=1 for exactly 1 cycle.
//  3. Down wrap: load 16'h0001, en=1, up_dn=0 -> 16'h0000, then 16'h9999 with cout=1.
//  4. Carry chain: load 16'h1239, one up step -> 16'h1240. Step down from there -> 16'h1239.
//  5. Priority and clamp:
//     - clr=1, load=1, en=1 together -> 16'h0000.
//     - load 16'hF3A9 -> 16'h9399.
//  6. CASCADE_CNT_CMP_EN: cmp_val=16'h0005, count up from 0 -> cmp_hit=1 for exactly one cycle,
//     the cycle after cnt=16'h0005.

Source files
------------

// File: rtl/cascade_cnt_pkg.sv
// Shared constants and helpers for the cascaded modulo counter.
// Optional compare feature is enabled in the top by defining CASCADE_CNT_CMP_EN.
package cascade_cnt_pkg;

  localparam logic CNT_DIR_UP = 1'b1;
  localparam logic CNT_DIR_DN = 1'b0;

  localparam int DEF_DIGITS  = 4;
  localparam int DEF_DIGIT_W = 4;
  localparam int DEF_MODULUS = 10;

  // Out-of-range digit values are pulled down to the largest legal digit.
  function automatic int clamp_digit(input int value, input int modulus);
    return (value > modulus - 1) ? modulus - 1 : value;
  endfunction

endpackage

// File: rtl/mod_digit_cell.sv
// One modulo-MODULUS digit of the cascade; steps up or down when its step input is high.
// Exposes at_max/at_zero so the top can build the carry/borrow chain.
module mod_digit_cell
  import cascade_cnt_pkg::*;
#(
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int MODULUS = DEF_MODULUS
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               step,
  input  logic               up_dn,
  input  logic               clr,
  input  logic               load,
  input  logic [DIGIT_W-1:0] ld_digit,
  output logic [DIGIT_W-1:0] digit,
  output logic               at_max,
  output logic               at_zero
);

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MODULUS - 1);

  logic [DIGIT_W-1:0] digit_reg;
  logic [DIGIT_W-1:0] digit_next;

  assign at_max  = (digit_reg == MAX_D);
  assign at_zero = (digit_reg == '0);
  assign digit   = digit_reg;

  always_comb begin
    digit_next = digit_reg;
    if (clr) begin
      digit_next = '0;
    end else if (load) begin
      digit_next = DIGIT_W'(clamp_digit(int'(32'(ld_digit)), MODULUS));
    end else if (step) begin
      if (up_dn == CNT_DIR_DN) begin
        digit_next = at_zero ? MAX_D : digit_reg - DIGIT_W'(1);
      end else begin
        digit_next = at_max ? '0 : digit_reg + DIGIT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      digit_reg <= '0;
    end else begin
      digit_reg <= digit_next;
    end
  end

endmodule

// File: rtl/cascade_mod_counter.sv
// Multi-digit cascaded modulo counter with up/down, clear, load, enable and wrap pulse.
// Define CASCADE_CNT_CMP_EN to add the registered cmp_val/cmp_hit comparator.
module cascade_mod_counter
  import cascade_cnt_pkg::*;
#(
  parameter int DIGITS  = DEF_DIGITS,
  parameter int DIGIT_W = DEF_DIGIT_W,
  parameter int MODULUS = DEF_MODULUS,
  localparam int W      = DIGITS * DIGIT_W
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         en,
  input  logic         up_dn,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt,
  output logic         cout
`ifdef CASCADE_CNT_CMP_EN
  ,
  input  logic [W-1:0] cmp_val,
  output logic         cmp_hit
`endif
);

  logic [DIGITS:0]   step_chain;
  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic              count_up;
  logic              cout_reg;
  logic              cout_next;

  assign count_up      = (up_dn == CNT_DIR_UP);
  assign step_chain[0] = en;

  // A digit steps only when every digit below it is at its carry/borrow boundary.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    mod_digit_cell #(
      .DIGIT_W(DIGIT_W),
      .MODULUS(MODULUS)
    ) u_cell (
      .clk     (clk),
      .rstn    (rstn),
      .step    (step_chain[gi]),
      .up_dn   (up_dn),
      .clr     (clr),
      .load    (load),
      .ld_digit(load_val[gi*DIGIT_W +: DIGIT_W]),
      .digit   (cnt[gi*DIGIT_W +: DIGIT_W]),
      .at_max  (at_max[gi]),
      .at_zero (at_zero[gi])
    );

    assign step_chain[gi+1] = step_chain[gi] & (count_up ? at_max[gi] : at_zero[gi]);
  end

  // Carry out of the top digit is the full-range wrap.
  assign cout_next = step_chain[DIGITS] & ~clr & ~load;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cout_reg <= 1'b0;
    end else begin
      cout_reg <= cout_next;
    end
  end

  assign cout = cout_reg;

`ifdef CASCADE_CNT_CMP_EN
  logic cmp_hit_reg;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmp_hit_reg <= 1'b0;
    end else begin
      cmp_hit_reg <= (cnt == cmp_val);
    end
  end

  assign cmp_hit = cmp_hit_reg;
`endif

endmodule

// File: tb/tb_cascade_mod_counter.sv
// Randomised and directed bench for cascade_mod_counter against an integer-valued reference model.
// Compare checks run only when CASCADE_CNT_CMP_EN is defined.
module tb_cascade_mod_counter;

  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 4;
  localparam int MODULUS = 10;
  localparam int W       = DIGITS * DIGIT_W;
  localparam int RANGE   = MODULUS ** DIGITS;

  logic         clk;
  logic         rstn;
  logic         en;
  logic         up_dn;
  logic         clr;
  logic         load;
  logic [W-1:0] load_val;
  logic [W-1:0] cnt;
  logic         cout;
`ifdef CASCADE_CNT_CMP_EN
  logic [W-1:0] cmp_val;
  logic         cmp_hit;
`endif

  int checks;
  int failures;

  int m_val;
  bit m_cout;
  bit m_hit;

  cascade_mod_counter #(
    .DIGITS (DIGITS),
    .DIGIT_W(DIGIT_W),
    .MODULUS(MODULUS)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .en      (en),
    .up_dn   (up_dn),
    .clr     (clr),
    .load    (load),
    .load_val(load_val),
    .cnt     (cnt),
    .cout    (cout)
`ifdef CASCADE_CNT_CMP_EN
    ,
    .cmp_val (cmp_val),
    .cmp_hit (cmp_hit)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] to_digits(input int v);
    logic [W-1:0] r;
    int           t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*DIGIT_W +: DIGIT_W] = DIGIT_W'(t % MODULUS);
      t = t / MODULUS;
    end
    return r;
  endfunction

  function automatic int from_load(input logic [W-1:0] lv);
    int v;
    int d;
    v = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(lv[i*DIGIT_W +: DIGIT_W]);
      if (d > MODULUS - 1) d = MODULUS - 1;
      v = v * MODULUS + d;
    end
    return v;
  endfunction

  // Advance the model by one clock using the inputs present at that edge, then compare.
  task automatic cycle(input string tag);
    logic [W-1:0] prev;
    prev = to_digits(m_val);
`ifdef CASCADE_CNT_CMP_EN
    m_hit = (prev == cmp_val);
`else
    m_hit = 1'b0;
`endif
    m_cout = 1'b0;
    if (clr) begin
      m_val = 0;
    end else if (load) begin
      m_val = from_load(load_val);
    end else if (en) begin
      if (up_dn) begin
        m_cout = (m_val == RANGE - 1);
        m_val  = (m_val + 1) % RANGE;
      end else begin
        m_cout = (m_val == 0);
        m_val  = (m_val + RANGE - 1) % RANGE;
      end
    end
    @(posedge clk);
    #1;
    check({tag, "_cnt"}, 32'(cnt), 32'(to_digits(m_val)));
    check({tag, "_cout"}, 32'(cout), 32'(m_cout));
`ifdef CASCADE_CNT_CMP_EN
    check({tag, "_hit"}, 32'(cmp_hit), 32'(m_hit));
`endif
    $display("%s: en=%0b up=%0b clr=%0b load=%0b lv=%h -> cnt=%h cout=%0b",
             tag, en, up_dn, clr, load, load_val, cnt, cout);
  endtask

  task automatic idle_inputs();
    en = 1'b0; up_dn = 1'b1; clr = 1'b0; load = 1'b0; load_val = '0;
  endtask

  task automatic do_load(input logic [W-1:0] v);
    idle_inputs();
    load = 1'b1; load_val = v;
    cycle("load");
    load = 1'b0;
  endtask

  int hits;

  initial begin
    checks   = 0;
    failures = 0;
    m_val    = 0;
    m_cout   = 1'b0;
    m_hit    = 1'b0;
    idle_inputs();
`ifdef CASCADE_CNT_CMP_EN
    cmp_val = 16'h0005;
`endif
    rstn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_cnt", 32'(cnt), 32'h0);
    check("reset_cout", 32'(cout), 32'h0);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // Up wrap
    do_load(16'h9998);
    en = 1'b1; up_dn = 1'b1;
    cycle("upwrap1");
    check("upwrap1_val", 32'(cnt), 32'h9999);
    cycle("upwrap2");
    check("upwrap2_val", 32'(cnt), 32'h0000);
    check("upwrap2_pulse", 32'(cout), 32'h1);
    cycle("upwrap3");
    check("upwrap3_pulse", 32'(cout), 32'h0);

    // Down wrap
    do_load(16'h0001);
    en = 1'b1; up_dn = 1'b0;
    cycle("dnwrap1");
    check("dnwrap1_val", 32'(cnt), 32'h0000);
    cycle("dnwrap2");
    check("dnwrap2_val", 32'(cnt), 32'h9999);
    check("dnwrap2_pulse", 32'(cout), 32'h1);

    // Carry chain
    do_load(16'h1239);
    en = 1'b1; up_dn = 1'b1;
    cycle("carry_up");
    check("carry_up_val", 32'(cnt), 32'h1240);
    up_dn = 1'b0;
    cycle("carry_dn");
    check("carry_dn_val", 32'(cnt), 32'h1239);

    // Priority and clamp
    clr = 1'b1; load = 1'b1; en = 1'b1; load_val = 16'h5555;
    cycle("prio");
    check("prio_val", 32'(cnt), 32'h0000);
    do_load(16'hF3A9);
    check("clamp_val", 32'(cnt), 32'h9399);
    load = 1'b1; en = 1'b1; up_dn = 1'b1; load_val = 16'h0420;
    cycle("load_over_en");
    check("load_over_en_val", 32'(cnt), 32'h0420);

    // Hold with nothing active
    idle_inputs();
    cycle("hold");
    check("hold_val", 32'(cnt), 32'h0420);

`ifdef CASCADE_CNT_CMP_EN
    idle_inputs();
    clr = 1'b1;
    cycle("cmp_clr");
    clr = 1'b0; en = 1'b1; up_dn = 1'b1;
    hits = 0;
    for (int i = 0; i < 10; i++) begin
      cycle("cmp_up");
      if (cmp_hit) begin
        hits++;
        check("cmp_hit_after5", 32'(cnt), 32'h0006);
      end
    end
    check("cmp_hit_count", 32'(hits), 32'd1);
`endif

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      en    = ($urandom_range(0, 9) < 8);
      up_dn = $urandom_range(0, 1) == 1;
      clr   = ($urandom_range(0, 49) == 0);
      load  = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 1) == 1)
        load_val = W'($urandom);
      else
        load_val = ($urandom_range(0, 1) == 1) ? 16'h9997 : 16'h0002;
      cycle("rand");
    end

    // Asynchronous reset mid-count
    do_load(16'h0457);
    en = 1'b1; up_dn = 1'b1;
    @(posedge clk);
    #3;
    rstn = 1'b0;
    #1;
    check("async_rst_cnt", 32'(cnt), 32'h0);
    check("async_rst_cout", 32'(cout), 32'h0);
    @(posedge clk);
    #1;
    check("rst_hold_cnt", 32'(cnt), 32'h0);
    m_val = 0;
    idle_inputs();
    rstn = 1'b1;
    en = 1'b1;
    cycle("post_rst");
    check("post_rst_val", 32'(cnt), 32'h0001);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
